// File: rtl/processor_pkg.sv
// Shared constants and types for the single-cycle RV64I subset core.
// The data memory is built only when PROCESSOR_DMEM_EN is defined.
package processor_pkg;

    localparam int unsigned XLEN = 64;

    localparam logic [6:0] OpcOp    = 7'b0110011;
    localparam logic [6:0] OpcOpImm = 7'b0010011;
    localparam logic [6:0] OpcLui   = 7'b0110111;
    localparam logic [6:0] OpcLoad  = 7'b0000011;
    localparam logic [6:0] OpcStore = 7'b0100011;

    localparam logic [2:0] F3AddSub = 3'b000;
    localparam logic [2:0] F3Sll    = 3'b001;
    localparam logic [2:0] F3Word   = 3'b010;
    localparam logic [2:0] F3Xor    = 3'b100;
    localparam logic [2:0] F3Srl    = 3'b101;
    localparam logic [2:0] F3Or     = 3'b110;
    localparam logic [2:0] F3And    = 3'b111;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Sub  = 7'b0100000;

    typedef enum logic [2:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluXor,
        AluSll,
        AluSrl
    } alu_op_e;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/processor_alu.sv
// Combinational 64-bit ALU; shifts use the low six bits of the second operand.
module processor_alu
    import processor_pkg::*;
(
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  alu_op_e         i_op,
    output logic [XLEN-1:0] o_y
);

    always_comb begin
        o_y = i_a + i_b;
        case (i_op)
            AluAdd:  o_y = i_a + i_b;
            AluSub:  o_y = i_a - i_b;
            AluAnd:  o_y = i_a & i_b;
            AluOr:   o_y = i_a | i_b;
            AluXor:  o_y = i_a ^ i_b;
            AluSll:  o_y = i_a << i_b[5:0];
            AluSrl:  o_y = i_a >> i_b[5:0];
            default: o_y = i_a + i_b;
        endcase
    end

endmodule

// File: rtl/processor.sv
// Single-cycle RV64I subset core: decode, execute and writeback on every rising edge.
// Data memory with LW/SW is present only when PROCESSOR_DMEM_EN is defined.
module processor
    import processor_pkg::*;
#(
    parameter int unsigned DMEM_WORDS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instruction,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] r_regs [1:31];
    logic [XLEN-1:0] r_result;

    logic [6:0]      w_opcode;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_alu_a;
    logic [XLEN-1:0] w_alu_b;
    logic [XLEN-1:0] w_alu_y;
    alu_op_e         w_alu_op;
    logic            w_valid;
    logic            w_is_store;
    logic            w_rd_we;
    logic [XLEN-1:0] w_wb_data;

    assign w_opcode = instruction[6:0];
    assign w_rd     = instruction[11:7];
    assign w_funct3 = instruction[14:12];
    assign w_rs1    = instruction[19:15];
    assign w_rs2    = instruction[24:20];
    assign w_funct7 = instruction[31:25];
    assign w_imm_i  = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
    assign w_imm_u  = {{(XLEN-32){instruction[31]}}, instruction[31:12], 12'b0};

    assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];

`ifdef PROCESSOR_DMEM_EN
    localparam int unsigned AW = $clog2(DMEM_WORDS);

    logic [31:0]     r_dmem [DMEM_WORDS];
    logic [XLEN-1:0] w_imm_s;
    logic [AW-1:0]   w_mem_idx;
    logic [31:0]     w_mem_rdata;
    logic            w_is_load;

    assign w_imm_s = {{(XLEN-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
    // The ALU adder forms rs1 + offset; byte offset bits are dropped and the index wraps.
    assign w_mem_idx   = w_alu_y[AW+1:2];
    assign w_mem_rdata = r_dmem[w_mem_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dmem <= '{default: '0};
        end else if (w_is_store) begin
            r_dmem[w_mem_idx] <= w_rs2_val[31:0];
        end
    end
`endif

    always_comb begin
        w_valid    = 1'b0;
        w_is_store = 1'b0;
`ifdef PROCESSOR_DMEM_EN
        w_is_load  = 1'b0;
`endif
        w_alu_op   = AluAdd;
        w_alu_a    = w_rs1_val;
        w_alu_b    = w_rs2_val;
        case (w_opcode)
            OpcOp: begin
                w_valid = 1'b1;
                case ({w_funct7, w_funct3})
                    {F7Base, F3AddSub}: w_alu_op = AluAdd;
                    {F7Sub,  F3AddSub}: w_alu_op = AluSub;
                    {F7Base, F3And}:    w_alu_op = AluAnd;
                    {F7Base, F3Or}:     w_alu_op = AluOr;
                    {F7Base, F3Xor}:    w_alu_op = AluXor;
                    {F7Base, F3Sll}:    w_alu_op = AluSll;
                    {F7Base, F3Srl}:    w_alu_op = AluSrl;
                    default:            w_valid  = 1'b0;
                endcase
            end
            OpcOpImm: begin
                w_valid = 1'b1;
                w_alu_b = w_imm_i;
                case (w_funct3)
                    F3AddSub: w_alu_op = AluAdd;
                    F3And:    w_alu_op = AluAnd;
                    F3Or:     w_alu_op = AluOr;
                    F3Xor:    w_alu_op = AluXor;
                    // RV64 shift-immediates carry a 6-bit shamt; upper funct bits must be zero.
                    F3Sll: begin
                        w_alu_op = AluSll;
                        w_valid  = (instruction[31:26] == 6'd0);
                    end
                    F3Srl: begin
                        w_alu_op = AluSrl;
                        w_valid  = (instruction[31:26] == 6'd0);
                    end
                    default:  w_valid = 1'b0;
                endcase
            end
            OpcLui: begin
                w_valid = 1'b1;
                w_alu_a = '0;
                w_alu_b = w_imm_u;
            end
`ifdef PROCESSOR_DMEM_EN
            OpcLoad: begin
                w_valid   = (w_funct3 == F3Word);
                w_is_load = w_valid;
                w_alu_b   = w_imm_i;
            end
            OpcStore: begin
                w_valid    = (w_funct3 == F3Word);
                w_is_store = w_valid;
                w_alu_b    = w_imm_s;
            end
`endif
            default: w_valid = 1'b0;
        endcase
    end

    processor_alu u_alu (
        .i_a  (w_alu_a),
        .i_b  (w_alu_b),
        .i_op (w_alu_op),
        .o_y  (w_alu_y)
    );

    always_comb begin
        w_wb_data = w_alu_y;
`ifdef PROCESSOR_DMEM_EN
        if (w_is_load) begin
            w_wb_data = sext32(w_mem_rdata);
        end else if (w_is_store) begin
            w_wb_data = w_rs2_val;
        end
`endif
    end

    assign w_rd_we = w_valid && !w_is_store && (w_rd != 5'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_result <= '0;
            r_regs   <= '{default: '0};
        end else if (w_valid) begin
            r_result <= w_wb_data;
            if (w_rd_we) begin
                r_regs[w_rd] <= w_wb_data;
            end
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_processor.sv
// Directed-vector bench for processor; memory vectors run when PROCESSOR_DMEM_EN is defined.
module tb_processor;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic [63:0] result;

    int unsigned n_checks;
    int unsigned n_errors;

    processor #(
        .DMEM_WORDS (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Drive one instruction between edges, then sample just after the executing edge.
    task automatic exec(input logic [31:0] ins, input string tag, input logic [63:0] exp);
        @(negedge clk);
        instruction = ins;
        @(posedge clk);
        #1;
        check_eq(tag, result, exp);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b0;
        instruction = 32'h0000_0000;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_result", result, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        exec(32'h00A00093, "addi_x1", 64'd10);
        exec(32'h01408113, "addi_x2", 64'd30);
        exec(32'h002081B3, "add_x3", 64'd40);
        exec(32'h40218233, "sub_x4", 64'd10);

        exec(32'h000642B7, "lui_t0", 64'h64000);
        exec(32'h03200313, "addi_t1", 64'd50);
        exec(32'h0062F3B3, "and_t2", 64'd0);
        exec(32'h0072EE33, "or_t3", 64'h64000);
        exec(32'h0072CEB3, "xor_t4", 64'h64000);
        exec(32'h00137F13, "andi_t5", 64'd0);
        exec(32'h006F6F93, "ori_t6", 64'd6);
        exec(32'h009FC413, "xori_s0", 64'd15);

        exec(32'h00245493, "srli_s1", 64'd3);
        exec(32'h00949933, "sll_s2", 64'd24);
        exec(32'h009959B3, "srl_s3", 64'd3);
        exec(32'h00241493, "slli_s1", 64'd60);

        exec(32'h00000000, "unsup_zero_hold", 64'd60);
        exec(32'h409959B3, "unsup_sra_hold", 64'd60);
        exec(32'h00098A13, "unsup_no_write", 64'd3);
        exec(32'h00500013, "addi_x0_result", 64'd5);
        exec(32'h00300AB3, "x0_reads_zero", 64'd40);

        exec(32'h00108093, "reexec_1", 64'd11);
        exec(32'h00108093, "reexec_2", 64'd12);

        exec(32'h80000B37, "lui_sext", 64'hFFFF_FFFF_8000_0000);
        exec(32'h016B0BB3, "add_wrap", 64'hFFFF_FFFF_0000_0000);
        exec(32'hFFF00C13, "addi_neg", 64'hFFFF_FFFF_FFFF_FFFF);
        exec(32'h03FC1C93, "slli_63", 64'h8000_0000_0000_0000);
        exec(32'h018CDD33, "srl_rs2_63", 64'd1);

`ifdef PROCESSOR_DMEM_EN
        exec(32'h00302023, "sw_gp", 64'd40);
        exec(32'h00002503, "lw_a0", 64'd40);
        exec(32'h01802223, "sw_ones", 64'hFFFF_FFFF_FFFF_FFFF);
        exec(32'h00402583, "lw_sext", 64'hFFFF_FFFF_FFFF_FFFF);
        exec(32'h08002603, "lw_wrap", 64'd40);
        exec(32'h00702683, "lw_low_bits", 64'hFFFF_FFFF_FFFF_FFFF);
`else
        exec(32'h00302023, "sw_unsup", 64'd1);
        exec(32'h00002503, "lw_unsup", 64'd1);
`endif

        // Asynchronous reset mid-sequence with an instruction in flight.
        @(negedge clk);
        instruction = 32'h00A00093;
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_reset", result, 64'd0);
        @(posedge clk);
        #1;
        check_eq("reset_discard", result, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        exec(32'h00018DB3, "regs_cleared", 64'd0);
`ifdef PROCESSOR_DMEM_EN
        exec(32'h00402583, "dmem_cleared", 64'd0);
`endif
        exec(32'h00A00093, "post_reset_addi", 64'd10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
